// File: rtl/hearing_aid_pkg.sv
// hearing_aid_pkg: constants and types shared across the hearing-aid audio datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: AUDIO_W sample width, signed sample_t, I2S_FRAME_BITS stereo frame length.
package hearing_aid_pkg;

  localparam int AUDIO_W        = 16;
  localparam int I2S_FRAME_BITS = 32;

  typedef logic signed [AUDIO_W-1:0] sample_t;

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: small register-based sample FIFO with a separate occupancy counter.
// Latency: a pushed word is readable on dout the cycle after the push; dout is the head, read combinationally.
// Backpressure: none internally; the caller must not push when full unless it pops in the same cycle.
// Ports: clk, rst_n (async active-low); push/din write side; pop/dout read side; level, full, empty status.
module audio_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;

  assign dout  = mem[rd_ptr];
  assign level = count;
  assign empty = (count == '0);
  assign full  = (count == LVL_W'(DEPTH));

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers are exactly log2(DEPTH) bits so they wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2s_audio_transmitter.sv
// i2s_audio_transmitter: I2S master serializer; each mono sample is sent on both left and right slots.
// Latency: the FIFO head appears on i2s_sdata in the pop-tick cycle (bclk fall entering slot 1).
// Backpressure: none; samples arriving with the FIFO full and no pop are dropped and flagged on overflow.
// Ports: clk, rst_n (async active-low); audio_in/audio_valid sample input; i2s_bclk/i2s_lrclk/i2s_sdata
//        serial output; fifo_level occupancy; overflow/underrun one-cycle status pulses.
// Build option: define I2S_TX_UNDERRUN_HOLD_EN to re-send the last popped sample on underrun (else silence).
module i2s_audio_transmitter
  import hearing_aid_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [AUDIO_W-1:0]              audio_in,
  input  logic                            audio_valid,
  output logic                            i2s_bclk,
  output logic                            i2s_lrclk,
  output logic                            i2s_sdata,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overflow,
  output logic                            underrun
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = $clog2(I2S_FRAME_BITS);

  logic [DIV_W-1:0]          div_cnt;
  logic [SLOT_W-1:0]         bit_cnt;
  logic [I2S_FRAME_BITS-1:0] shifter;
  logic                      bclk_q;
  logic                      lrclk_q;
  logic                      sdata_q;
  logic                      overflow_q;
  logic                      underrun_q;

  logic                      div_wrap;
  logic                      fall_tick;
  logic                      pop_tick;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [AUDIO_W-1:0]        fifo_dout;
  sample_t                   tx_sample;
  logic [I2S_FRAME_BITS-1:0] frame;

  assign div_wrap  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign fall_tick = div_wrap & bclk_q;
  // Fall edge entering slot 1: the slot-0 bit (previous LSB) has gone out, start the new word.
  assign pop_tick  = fall_tick & (bit_cnt == '0);
  assign fifo_pop  = pop_tick & ~fifo_empty;
  // A same-cycle pop frees a slot, so a full FIFO still accepts the sample.
  assign fifo_push = audio_valid & (~fifo_full | fifo_pop);

  audio_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AUDIO_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (audio_in),
    .dout  (fifo_dout),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef I2S_TX_UNDERRUN_HOLD_EN
  sample_t hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        hold_q <= '0;
    else if (fifo_pop) hold_q <= sample_t'(fifo_dout);
  end

  always_comb begin
    tx_sample = hold_q;
    if (!fifo_empty) tx_sample = sample_t'(fifo_dout);
  end
`else
  always_comb begin
    tx_sample = '0;
    if (!fifo_empty) tx_sample = sample_t'(fifo_dout);
  end
`endif

  assign frame = {tx_sample, tx_sample};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      bclk_q     <= 1'b0;
      bit_cnt    <= '1;
      lrclk_q    <= 1'b1;
      shifter    <= '0;
      sdata_q    <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= audio_valid & ~fifo_push;
      underrun_q <= pop_tick & fifo_empty;
      if (div_wrap) begin
        div_cnt <= '0;
        bclk_q  <= ~bclk_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall_tick) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == '1)
          lrclk_q <= 1'b0;
        else if (bit_cnt == SLOT_W'(I2S_FRAME_BITS/2 - 1))
          lrclk_q <= 1'b1;
        if (pop_tick) begin
          shifter <= frame;
          sdata_q <= frame[I2S_FRAME_BITS-1];
        end else begin
          shifter <= shifter << 1;
          sdata_q <= shifter[I2S_FRAME_BITS-2];
        end
      end
    end
  end

  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign overflow  = overflow_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_i2s_audio_transmitter.sv
// tb_i2s_audio_transmitter: directed bench with a cycle-indexed reference model of the I2S transmitter.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2s_audio_transmitter;

  localparam int DIV   = 4;
  localparam int DEPTH = 8;
  localparam int HP    = 2 * DIV;  // clk cycles per bclk period

  logic                       clk         = 1'b0;
  logic                       rst_n       = 1'b0;
  logic [15:0]                audio_in    = '0;
  logic                       audio_valid = 1'b0;
  logic                       i2s_bclk;
  logic                       i2s_lrclk;
  logic                       i2s_sdata;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;
  logic                       overflow;
  logic                       underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_audio_transmitter #(
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_in    (audio_in),
    .audio_valid (audio_valid),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_sdata   (i2s_sdata),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .underrun    (underrun)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: mn is the index of the last clk edge since reset release
  // (-1 while in reset). Outputs follow from mn by plain arithmetic; the FIFO is a queue.
  int          mn = -1;
  logic [15:0] q[$];
  logic [15:0] m_hold = '0;
  logic        m_ovf = 1'b0;
  logic        m_und = 1'b0;
  logic [31:0] fw [0:63];  // word sent in each frame
  logic        cap [0:1023]; // sdata observed after each bclk fall, by fall index
  int          m_f;
  logic [15:0] m_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mn     = -1;
      q.delete();
      m_hold = '0;
      m_ovf  = 1'b0;
      m_und  = 1'b0;
    end else begin
      mn++;
      m_ovf = 1'b0;
      m_und = 1'b0;
      if ((mn + 1) % HP == 0) begin
        m_f = (mn + 1) / HP;
        if ((m_f - 1) % 32 == 1) begin
          if (q.size() == 0) begin
            m_und = 1'b1;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
            m_s = m_hold;
`else
            m_s = 16'h0000;
`endif
          end else begin
            m_s    = q.pop_front();
            m_hold = m_s;
          end
          if ((m_f - 1) / 32 < 64) fw[(m_f - 1) / 32] = {m_s, m_s};
        end
      end
      if (audio_valid) begin
        if (q.size() < DEPTH) q.push_back(audio_in);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_lrclk();
    int f;
    f = (mn + 1) / HP;
    if (f == 0) return 1'b1;
    return ((f - 1) % 32) >= 16;
  endfunction

  function automatic logic exp_sdata();
    int f, slot, fr;
    f = (mn + 1) / HP;
    if (f == 0) return 1'b0;
    slot = (f - 1) % 32;
    fr   = (f - 1) / 32;
    if (slot == 0) return (fr == 0 || fr > 64) ? 1'b0 : fw[fr-1][0];
    return (fr < 64) ? fw[fr][32-slot] : 1'b0;
  endfunction

  always @(negedge clk) begin
    chk("bclk",     32'(i2s_bclk),   32'(((mn + 1) / DIV) % 2));
    chk("lrclk",    32'(i2s_lrclk),  32'(exp_lrclk()));
    chk("sdata",    32'(i2s_sdata),  32'(exp_sdata()));
    chk("level",    32'(fifo_level), 32'(q.size()));
    chk("overflow", 32'(overflow),   32'(m_ovf));
    chk("underrun", 32'(underrun),   32'(m_und));
    if (rst_n && mn >= 0 && (mn + 1) % HP == 0 && (mn + 1) / HP < 1024)
      cap[(mn + 1) / HP] = i2s_sdata;
  end

  // Reassemble frame fr's 32-bit word from slots 1..31 and the following slot 0.
  function automatic logic [31:0] word_of(input int fr);
    logic [31:0] w;
    for (int k = 1; k <= 32; k++) w[32-k] = cap[32*fr + 1 + k];
    return w;
  endfunction

  // Returns 1 ns after edge n (counted from reset release).
  task automatic to_cyc(input int n);
    int guard;
    guard = 0;
    while (mn < n) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 20000) begin
        errors++;
        $display("FAIL to_cyc timeout: reached %0d required %0d", mn, n);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "cycle budget exhausted");
      end
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    audio_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bclk",  32'(i2s_bclk),  32'd0);
    chk("rst_lrclk", 32'(i2s_lrclk), 32'd1);
    chk("rst_sdata", 32'(i2s_sdata), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic startup(input bit push);
    to_cyc(1);
    chk("st_level0", 32'(fifo_level), 32'd0);
    if (push) begin
      audio_valid = 1'b1;
      audio_in    = 16'hA5C3;
    end
    to_cyc(2);
    audio_valid = 1'b0;
    chk("st_bclk_c2", 32'(i2s_bclk), 32'd0);
    if (push) chk("st_level1", 32'(fifo_level), 32'd1);
    to_cyc(3);
    chk("st_bclk_c3", 32'(i2s_bclk), 32'd1);
    to_cyc(6);
    chk("st_lrclk_c6", 32'(i2s_lrclk), 32'd1);
    to_cyc(7);
    chk("st_lrclk_c7", 32'(i2s_lrclk), 32'd0);
    chk("st_bclk_c7",  32'(i2s_bclk),  32'd0);
  endtask

  initial begin
    // Reset, startup timing, single sample A5C3, then 7FFF and an underrun frame.
    do_reset();
    startup(1'b1);
    to_cyc(14);
    chk("t2_level_c14", 32'(fifo_level), 32'd1);
    to_cyc(15);
    chk("t2_level_c15", 32'(fifo_level), 32'd0);
    chk("t2_msb_c15",   32'(i2s_sdata),  32'd1);
    chk("t2_und_c15",   32'(underrun),   32'd0);
    to_cyc(99);
    audio_valid = 1'b1;
    audio_in    = 16'h7FFF;
    to_cyc(100);
    audio_valid = 1'b0;
    to_cyc(264);
    chk("t2_word", word_of(0), 32'hA5C3A5C3);
    to_cyc(271);
    chk("t3_und_f1", 32'(underrun), 32'd0);
    to_cyc(520);
    chk("t3_word_f1", word_of(1), 32'h7FFF7FFF);
    to_cyc(527);
    chk("t3_und_f2", 32'(underrun), 32'd1);
    to_cyc(528);
    chk("t3_und_after", 32'(underrun), 32'd0);
    to_cyc(776);
`ifdef I2S_TX_UNDERRUN_HOLD_EN
    chk("t3_word_f2", word_of(2), 32'h7FFF7FFF);
`else
    chk("t3_word_f2", word_of(2), 32'h00000000);
`endif

    // Overflow: nine pushes at edges 1..9, then a push coinciding with the first pop (edge 15).
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      to_cyc(k - 1);
      if (k == 9) begin
        chk("t4_level_full", 32'(fifo_level), 32'd8);
        chk("t4_ovf_c8",     32'(overflow),   32'd0);
      end
      audio_valid = 1'b1;
      audio_in    = 16'(16'h1000 + k);
    end
    to_cyc(9);
    audio_valid = 1'b0;
    chk("t4_ovf_c9",   32'(overflow),   32'd1);
    chk("t4_level_c9", 32'(fifo_level), 32'd8);
    to_cyc(10);
    chk("t4_ovf_c10", 32'(overflow), 32'd0);
    to_cyc(14);
    audio_valid = 1'b1;
    audio_in    = 16'hBEEF;
    to_cyc(15);
    audio_valid = 1'b0;
    chk("t5_ovf_c15",   32'(overflow),   32'd0);
    chk("t5_level_c15", 32'(fifo_level), 32'd8);
    for (int fr = 0; fr <= 8; fr++) begin
      logic [15:0] s;
      to_cyc(256*fr + 264);
      s = (fr < 8) ? 16'(16'h1001 + fr) : 16'hBEEF;
      chk("t45_word", word_of(fr), {s, s});
    end

    // Reset mid-frame at slot 10 with three samples queued.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      to_cyc(k - 1);
      audio_valid = 1'b1;
      audio_in    = 16'(16'h2000 + k);
    end
    to_cyc(4);
    audio_valid = 1'b0;
    to_cyc(87);
    chk("t6_level_pre", 32'(fifo_level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_bclk",  32'(i2s_bclk),   32'd0);
    chk("t6_lrclk", 32'(i2s_lrclk),  32'd1);
    chk("t6_sdata", 32'(i2s_sdata),  32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_ovf",   32'(overflow),   32'd0);
    chk("t6_und",   32'(underrun),   32'd0);
    do_reset();
    startup(1'b0);
    to_cyc(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
